// File: rtl/video_frame_controller.sv
// Frame-synchronous double buffer and view-select sequencer for the 7-segment video card.
// Optional blinking of masked digits is enabled by defining VIDEO_BLINK_EN.
module video_frame_controller #(
    parameter int FRAME_DIV    = 833333,
    parameter int DWELL_FRAMES = 60
`ifdef VIDEO_BLINK_EN
    , parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Wr_En,
    input  logic [2:0] Wr_Addr,
    input  logic [7:0] Wr_Data,
    input  logic       Swap_Req,
    input  logic [1:0] Mode_Sel,
`ifdef VIDEO_BLINK_EN
    input  logic [7:0] Blink_Mask,
`endif
    output logic       Swap_Pending,
    output logic       Frame_Tick,
    output logic [7:0] Video_Input0,
    output logic [7:0] Video_Input1,
    output logic [7:0] Video_Input2,
    output logic [7:0] Video_Input3,
    output logic [7:0] Video_Input4,
    output logic [7:0] Video_Input5,
    output logic [7:0] Video_Input6,
    output logic [7:0] Video_Input7,
    output logic       Direct_Video_Map,
    output logic       Register_View
);

    localparam int FW  = $clog2(FRAME_DIV);
    localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    typedef enum logic [1:0] {HEX, DIRECT, REGV} modeState_t;

    logic [FW-1:0]  frameCnt;
    logic [DWW-1:0] dwellCnt;
    logic [7:0]     back  [8];
    logic [7:0]     front [8];
    logic [7:0]     videoOut [8];
    logic           doCopy;
    modeState_t     state;
    modeState_t     autoNext;

    assign doCopy = Frame_Tick && Swap_Pending;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            frameCnt   <= '0;
            Frame_Tick <= 1'b0;
        end else begin
            Frame_Tick <= (frameCnt == FW'(FRAME_DIV - 1));
            if (frameCnt == FW'(FRAME_DIV - 1))
                frameCnt <= '0;
            else
                frameCnt <= frameCnt + 1'b1;
        end
    end

    // The copy reads the back buffer before this edge's write lands, so a
    // store in the copy cycle reaches the front only on the next swap.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 8; i++) begin
                back[i]  <= 8'h00;
                front[i] <= 8'h00;
            end
            Swap_Pending <= 1'b0;
        end else begin
            if (Wr_En)
                back[Wr_Addr] <= Wr_Data;
            if (doCopy)
                for (int i = 0; i < 8; i++)
                    front[i] <= back[i];
            if (Swap_Req)
                Swap_Pending <= 1'b1;
            else if (doCopy)
                Swap_Pending <= 1'b0;
        end
    end

    always_comb begin
        autoNext = HEX;
        case (state)
            HEX:     autoNext = REGV;
            REGV:    autoNext = DIRECT;
            DIRECT:  autoNext = HEX;
            default: autoNext = HEX;
        endcase
    end

    // Dwell is held at zero whenever auto-cycle is not selected, so entering
    // auto-cycle always starts a fresh dwell from the current view.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= HEX;
            dwellCnt         <= '0;
            Direct_Video_Map <= 1'b0;
            Register_View    <= 1'b0;
        end else begin
            if (Mode_Sel != 2'b11)
                dwellCnt <= '0;
            if (Frame_Tick) begin
                case (Mode_Sel)
                    2'b00: begin
                        state <= HEX;    Direct_Video_Map <= 1'b0; Register_View <= 1'b0;
                    end
                    2'b01: begin
                        state <= DIRECT; Direct_Video_Map <= 1'b1; Register_View <= 1'b0;
                    end
                    2'b10: begin
                        state <= REGV;   Direct_Video_Map <= 1'b0; Register_View <= 1'b1;
                    end
                    default: begin
                        if (dwellCnt == DWW'(DWELL_FRAMES - 1)) begin
                            dwellCnt         <= '0;
                            state            <= autoNext;
                            Direct_Video_Map <= (autoNext == DIRECT);
                            Register_View    <= (autoNext == REGV);
                        end else begin
                            dwellCnt <= dwellCnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef VIDEO_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blinkCnt;
    logic          blinkPhase;
    logic          blinkWrap;
    logic          nextPhase;
    logic [7:0]    nextFront [8];

    assign blinkWrap = Frame_Tick && (blinkCnt == BW'(BLINK_FRAMES - 1));
    assign nextPhase = blinkWrap ? ~blinkPhase : blinkPhase;

    always_comb begin
        for (int i = 0; i < 8; i++)
            nextFront[i] = doCopy ? back[i] : front[i];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
            for (int i = 0; i < 8; i++)
                videoOut[i] <= 8'h00;
        end else if (Frame_Tick) begin
            blinkPhase <= nextPhase;
            blinkCnt   <= blinkWrap ? '0 : blinkCnt + 1'b1;
            for (int i = 0; i < 8; i++)
                videoOut[i] <= (!nextPhase && Blink_Mask[i]) ? 8'hFF : nextFront[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 8; i++)
            videoOut[i] = front[i];
    end
`endif

    assign Video_Input0 = videoOut[0];
    assign Video_Input1 = videoOut[1];
    assign Video_Input2 = videoOut[2];
    assign Video_Input3 = videoOut[3];
    assign Video_Input4 = videoOut[4];
    assign Video_Input5 = videoOut[5];
    assign Video_Input6 = videoOut[6];
    assign Video_Input7 = videoOut[7];

endmodule

// File: tb/tb_video_frame_controller.sv
// Directed bench for video_frame_controller with FRAME_DIV=4, DWELL_FRAMES=2.
module tb_video_frame_controller;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Wr_En;
    logic [2:0] Wr_Addr;
    logic [7:0] Wr_Data;
    logic       Swap_Req;
    logic [1:0] Mode_Sel;
`ifdef VIDEO_BLINK_EN
    logic [7:0] Blink_Mask;
`endif
    logic       Swap_Pending, Frame_Tick, Direct_Video_Map, Register_View;
    logic [7:0] Video_Input0, Video_Input1, Video_Input2, Video_Input3;
    logic [7:0] Video_Input4, Video_Input5, Video_Input6, Video_Input7;

    int nChecks = 0;
    int nFails  = 0;

    always #5 Clock = ~Clock;

    video_frame_controller #(
        .FRAME_DIV(4),
        .DWELL_FRAMES(2)
`ifdef VIDEO_BLINK_EN
        , .BLINK_FRAMES(1)
`endif
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
        .Swap_Req(Swap_Req), .Mode_Sel(Mode_Sel),
`ifdef VIDEO_BLINK_EN
        .Blink_Mask(Blink_Mask),
`endif
        .Swap_Pending(Swap_Pending), .Frame_Tick(Frame_Tick),
        .Video_Input0(Video_Input0), .Video_Input1(Video_Input1),
        .Video_Input2(Video_Input2), .Video_Input3(Video_Input3),
        .Video_Input4(Video_Input4), .Video_Input5(Video_Input5),
        .Video_Input6(Video_Input6), .Video_Input7(Video_Input7),
        .Direct_Video_Map(Direct_Video_Map), .Register_View(Register_View)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Advance until a Frame_Tick cycle is being sampled (always moves at least one edge).
    task automatic waitTick();
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!Frame_Tick && k < 12);
        if (!Frame_Tick) begin
            nChecks++;
            nFails++;
            $display("FAIL waitTick: observed no Frame_Tick within %0d cycles, expected one", k);
        end
    endtask

    task automatic tickAndStep();
        waitTick();
        step(1);
    endtask

    initial begin
        Reset_n = 1'b0; Wr_En = 1'b0; Wr_Addr = 3'd0; Wr_Data = 8'h00;
        Swap_Req = 1'b0; Mode_Sel = 2'b00;
`ifdef VIDEO_BLINK_EN
        Blink_Mask = 8'h00;
`endif
        step(2);
        check("rst_vid0", Video_Input0, 8'h00);
        check("rst_vid7", Video_Input7, 8'h00);
        check("rst_dvm", Direct_Video_Map, 8'h0);
        check("rst_rv", Register_View, 8'h0);
        check("rst_pend", Swap_Pending, 8'h0);
        Reset_n = 1'b1;

        // first tick is 4 edges after release, then every 4
        step(3); check("tick_pre", Frame_Tick, 8'h0);
        step(1); check("tick_first", Frame_Tick, 8'h1);
        step(1); check("tick_width", Frame_Tick, 8'h0);
        step(2); check("tick_gap", Frame_Tick, 8'h0);
        step(1); check("tick_second", Frame_Tick, 8'h1);

        // write without swap must not reach the front
        Wr_En = 1'b1; Wr_Addr = 3'd3; Wr_Data = 8'hA5;
        step(1); Wr_En = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tickAndStep();
            check("noswap_vid3", Video_Input3, 8'h00);
        end
        waitTick();
        check("noswap_pend", Swap_Pending, 8'h0);
        Swap_Req = 1'b1;
        step(1); Swap_Req = 1'b0;
        check("req_pend", Swap_Pending, 8'h1);
        check("req_on_tick_nocopy", Video_Input3, 8'h00);
        waitTick();
        check("pend_hold_vid3", Video_Input3, 8'h00);
        step(1);
        check("swap_vid3", Video_Input3, 8'hA5);
        check("swap_pend_clr", Swap_Pending, 8'h0);

        // write and re-request in the copy cycle
        Wr_En = 1'b1; Wr_Addr = 3'd0; Wr_Data = 8'h77; Swap_Req = 1'b1;
        step(1); Wr_En = 1'b0; Swap_Req = 1'b0;
        waitTick();
        check("copy_cycle_pend", Swap_Pending, 8'h1);
        Wr_En = 1'b1; Wr_Addr = 3'd0; Wr_Data = 8'h3C; Swap_Req = 1'b1;
        step(1); Wr_En = 1'b0; Swap_Req = 1'b0;
        check("copy_old_vid0", Video_Input0, 8'h77);
        check("copy_rearm_pend", Swap_Pending, 8'h1);
        check("copy_vid3_kept", Video_Input3, 8'hA5);
        waitTick();
        check("copy_hold_vid0", Video_Input0, 8'h77);
        step(1);
        check("copy_new_vid0", Video_Input0, 8'h3C);
        check("copy_pend_clr", Swap_Pending, 8'h0);

        // auto-cycle HEX -> REGV -> DIRECT -> HEX, two ticks per view
        Mode_Sel = 2'b11;
        tickAndStep();
        check("auto1_rv", Register_View, 8'h0);
        check("auto1_dvm", Direct_Video_Map, 8'h0);
        waitTick();
        check("auto2_pre_rv", Register_View, 8'h0);
        step(1);
        check("auto2_rv", Register_View, 8'h1);
        check("auto2_dvm", Direct_Video_Map, 8'h0);
        tickAndStep();
        check("auto3_rv", Register_View, 8'h1);
        waitTick();
        check("auto4_pre_rv", Register_View, 8'h1);
        step(1);
        check("auto4_dvm", Direct_Video_Map, 8'h1);
        check("auto4_rv", Register_View, 8'h0);
        tickAndStep();
        check("auto5_dvm", Direct_Video_Map, 8'h1);
        tickAndStep();
        check("auto6_dvm", Direct_Video_Map, 8'h0);
        check("auto6_rv", Register_View, 8'h0);

        // leave auto mid-dwell for DIRECT
        tickAndStep();
        Mode_Sel = 2'b01;
        step(1);
        check("mid_dwell_hold", Direct_Video_Map, 8'h0);
        tickAndStep();
        check("mid_dwell_direct", Direct_Video_Map, 8'h1);
        check("mid_dwell_rv", Register_View, 8'h0);

        // async reset mid-cycle with a swap queued
        Swap_Req = 1'b1;
        step(1); Swap_Req = 1'b0;
        check("pre_rst_pend", Swap_Pending, 8'h1);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_dvm", Direct_Video_Map, 8'h0);
        check("arst_vid0", Video_Input0, 8'h00);
        check("arst_vid3", Video_Input3, 8'h00);
        check("arst_pend", Swap_Pending, 8'h0);
        check("arst_tick", Frame_Tick, 8'h0);
        Mode_Sel = 2'b00;
        step(1); Reset_n = 1'b1;
        Swap_Req = 1'b1;
        step(1); Swap_Req = 1'b0;
        tickAndStep();
        check("post_rst_back_vid0", Video_Input0, 8'h00);
        check("post_rst_back_vid3", Video_Input3, 8'h00);

`ifdef VIDEO_BLINK_EN
        Blink_Mask = 8'h01;
        Wr_En = 1'b1; Wr_Addr = 3'd0; Wr_Data = 8'h12;
        step(1); Wr_Addr = 3'd1; Wr_Data = 8'h34; Swap_Req = 1'b1;
        step(1); Wr_En = 1'b0; Swap_Req = 1'b0;
        // phase after the k-th tick since reset is 1 for even k; one tick so far
        tickAndStep();
        check("blink_vis_vid0", Video_Input0, 8'h12);
        check("blink_vis_vid1", Video_Input1, 8'h34);
        tickAndStep();
        check("blink_off_vid0", Video_Input0, 8'hFF);
        check("blink_off_vid1", Video_Input1, 8'h34);
        step(1);
        check("blink_between", Video_Input0, 8'hFF);
        tickAndStep();
        check("blink_on_vid0", Video_Input0, 8'h12);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
